// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the dual-issue SPU pipeline.
// Owns the fetch PC, reads one 64-bit instruction pair per cycle from
// synchronous instruction memory, and drives the IF/ID register with a
// {PC, instr1, instr2, find_nop, valid} bundle. A 1-entry skid buffer
// absorbs the read that is in flight when stall rises, and a branch
// redirect squashes everything in flight.
// Optional build macro IF_HALT_DETECT_EN: stop-opcode detection that halts fetch.
// Bit numbering is big-endian: bit 0 is the MSB, so pc[8] is the word-in-pair bit.
module if_fetch_unit #(
    parameter logic [0:31] NOP_INSTR = 32'h4020_0000,
    parameter logic [0:8]  RESET_PC  = 9'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [0:8]  branch_target,
    output logic        imem_rd_en,
    output logic [0:7]  imem_addr,
    input  logic [0:63] imem_rdata,
    output logic [0:8]  PC_out,
    output logic [0:31] instr1_out,
    output logic [0:31] instr2_out,
    output logic        find_nop_out,
    output logic        valid_out,
    output logic        halted_out
);

    typedef struct packed {
        logic [0:8]  pc;
        logic [0:31] instr1;
        logic [0:31] instr2;
        logic        find_nop;
        logic        valid;
    } bundle_t;

    localparam bundle_t BUBBLE = '{pc: 9'd0, instr1: NOP_INSTR, instr2: NOP_INSTR,
                                   find_nop: 1'b1, valid: 1'b0};

    logic [0:8] pc_q, pc_d;
    logic [0:8] rsp_pc_q, rsp_pc_d;
    logic       pend_q, pend_d;
    bundle_t    skid_q, skid_d;
    logic       skid_full_q, skid_full_d;
    bundle_t    out_q, out_d;
    bundle_t    formed;
    logic       halted;

`ifdef IF_HALT_DETECT_EN
    logic halt_q, halt_d;

    // Stop opcode: top 11 bits all zero in instr1 or in a really fetched instr2.
    function automatic logic is_stop(input bundle_t b);
        return (b.instr1[0:10] == 11'd0) || (!b.find_nop && (b.instr2[0:10] == 11'd0));
    endfunction

    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

    assign imem_addr    = pc_q[0:7];
    assign PC_out       = out_q.pc;
    assign instr1_out   = out_q.instr1;
    assign instr2_out   = out_q.instr2;
    assign find_nop_out = out_q.find_nop;
    assign valid_out    = out_q.valid;
    assign halted_out   = halted;

    // Issue a read only when nothing downstream or in the skid blocks it.
    always_comb begin
        imem_rd_en = !rst && !branch_valid && !stall && !skid_full_q && !halted;
    end

    // Shape the returning pair into a bundle; an odd PC uses only the odd word.
    always_comb begin
        formed       = BUBBLE;
        formed.pc    = rsp_pc_q;
        formed.valid = 1'b1;
        if (rsp_pc_q[8]) begin
            formed.instr1   = imem_rdata[32:63];
            formed.instr2   = NOP_INSTR;
            formed.find_nop = 1'b1;
        end else begin
            formed.instr1   = imem_rdata[0:31];
            formed.instr2   = imem_rdata[32:63];
            formed.find_nop = 1'b0;
        end
    end

    // Next-state for PC, pending read, skid and output register (branch beats stall).
    always_comb begin
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        pend_d      = imem_rd_en;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        out_d       = out_q;
`ifdef IF_HALT_DETECT_EN
        halt_d      = halt_q;
`endif
        if (imem_rd_en) begin
            rsp_pc_d = pc_q;
            pc_d     = pc_q + (pc_q[8] ? 9'd1 : 9'd2);
        end
        if (branch_valid) begin
            pc_d        = branch_target;
            skid_full_d = 1'b0;
            out_d       = BUBBLE;
`ifdef IF_HALT_DETECT_EN
            halt_d      = 1'b0;
`endif
        end else if (stall) begin
            if (pend_q) begin
                skid_d      = formed;
                skid_full_d = 1'b1;
            end
        end else if (skid_full_q) begin
            out_d       = skid_q;
            skid_full_d = 1'b0;
`ifdef IF_HALT_DETECT_EN
            if (is_stop(skid_q)) halt_d = 1'b1;
`endif
        end else if (pend_q) begin
            out_d = formed;
`ifdef IF_HALT_DETECT_EN
            if (is_stop(formed)) halt_d = 1'b1;
`endif
        end else begin
            out_d = BUBBLE;
        end
    end

    // Pipeline state registers; reset discards any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= 9'd0;
            pend_q      <= 1'b0;
            skid_q      <= BUBBLE;
            skid_full_q <= 1'b0;
            out_q       <= BUBBLE;
        end else begin
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            pend_q      <= pend_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            out_q       <= out_d;
        end
    end

`ifdef IF_HALT_DETECT_EN
    // Halt flag: set by a stop bundle, cleared by reset or a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed, table-driven bench for if_fetch_unit.
// Memory pair k holds words {2k, 2k+1}; word w is encoded as 32'hC000_0000 | w.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h4020_0000;
`ifdef IF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        logic       stall;
        logic       bv;
        logic [8:0] tgt;
        logic       ev;
        logic [8:0] epc;
        logic       erd;
        logic [7:0] eaddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [0:8]  branch_target = 9'd0;
    logic        imem_rd_en;
    logic [0:7]  imem_addr;
    logic [0:63] imem_rdata = 64'd0;
    logic [0:8]  PC_out;
    logic [0:31] instr1_out;
    logic [0:31] instr2_out;
    logic        find_nop_out;
    logic        valid_out;
    logic        halted_out;

    logic [63:0] mem [256];
    vec_t        vecs [31];
    int          checks = 0;
    int          errors = 0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
        .branch_target(branch_target), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .PC_out(PC_out), .instr1_out(instr1_out),
        .instr2_out(instr2_out), .find_nop_out(find_nop_out), .valid_out(valid_out),
        .halted_out(halted_out)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the read.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    function automatic logic [31:0] word_at(input logic [8:0] w);
        logic [63:0] p;
        p = mem[w[8:1]];
        return w[0] ? p[31:0] : p[63:32];
    endfunction

    task automatic cmp(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic [8:0] t);
        @(negedge clk);
        stall         = s;
        branch_valid  = b;
        branch_target = t;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [8:0] epc,
                               input logic erd, input logic [7:0] eaddr, input logic ehalt);
        logic [8:0]  p;
        logic [31:0] e1, e2;
        logic        efn;
        p   = ev ? epc : 9'd0;
        e1  = ev ? word_at(epc) : NOP;
        e2  = (ev && !epc[0]) ? word_at(epc + 9'd1) : NOP;
        efn = !ev || epc[0];
        cmp(tag, "valid", 64'(valid_out), 64'(ev));
        cmp(tag, "pc", 64'(PC_out), 64'(p));
        cmp(tag, "instr1", 64'(instr1_out), 64'(e1));
        cmp(tag, "instr2", 64'(instr2_out), 64'(e2));
        cmp(tag, "find_nop", 64'(find_nop_out), 64'(efn));
        cmp(tag, "rd_en", 64'(imem_rd_en), 64'(erd));
        cmp(tag, "addr", 64'(imem_addr), 64'(eaddr));
        cmp(tag, "halted", 64'(halted_out), 64'(ehalt));
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 9'd0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset", 1'b0, 9'd0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k] = {32'hC000_0000 | 32'(2 * k), 32'hC000_0000 | 32'(2 * k + 1)};
        end

        // stall, bv, tgt, valid, pc, rd_en, addr (one record per cycle after reset)
        vecs[0]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h01};
        vecs[2]  = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h000, 1'b1, 8'h02};
        vecs[3]  = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h002, 1'b1, 8'h03};
        vecs[4]  = '{1'b0, 1'b1, 9'h005, 1'b1, 9'h004, 1'b0, 8'h04};
        vecs[5]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h02};
        vecs[6]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h03};
        vecs[7]  = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h005, 1'b1, 8'h04};
        vecs[8]  = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h006, 1'b1, 8'h05};
        vecs[9]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h008, 1'b0, 8'h06};
        vecs[10] = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h008, 1'b0, 8'h06};
        vecs[11] = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h008, 1'b0, 8'h06};
        vecs[12] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h008, 1'b0, 8'h06};
        vecs[13] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h00A, 1'b1, 8'h06};
        vecs[14] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h07};
        vecs[15] = '{1'b0, 1'b1, 9'h1FE, 1'b1, 9'h00C, 1'b0, 8'h08};
        vecs[16] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'hFF};
        vecs[17] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h00};
        vecs[18] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h1FE, 1'b1, 8'h01};
        vecs[19] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h000, 1'b1, 8'h02};
        vecs[20] = '{1'b0, 1'b1, 9'h1FF, 1'b1, 9'h002, 1'b0, 8'h03};
        vecs[21] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'hFF};
        vecs[22] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h00};
        vecs[23] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h1FF, 1'b1, 8'h01};
        vecs[24] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h000, 1'b1, 8'h02};
        vecs[25] = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h002, 1'b0, 8'h03};
        vecs[26] = '{1'b1, 1'b1, 9'h005, 1'b1, 9'h002, 1'b0, 8'h03};
        vecs[27] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h02};
        vecs[28] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 8'h03};
        vecs[29] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h005, 1'b1, 8'h04};
        vecs[30] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h006, 1'b1, 8'h05};

        reset_dut();
        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].bv, vecs[i].tgt);
            checkOutput($sformatf("c%0d", i), vecs[i].ev, vecs[i].epc,
                        vecs[i].erd, vecs[i].eaddr, 1'b0);
        end

        // Reset asserted mid-cycle while the skid is full and a read is in flight.
        applyStimulus(1'b1, 1'b0, 9'd0);
        checkOutput("c31", 1'b1, 9'h008, 1'b0, 8'h06, 1'b0);
        @(negedge clk);
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async", 1'b0, 9'd0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        stall = 1'b0;
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("post_rst0", 1'b0, 9'd0, 1'b1, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("post_rst1", 1'b0, 9'd0, 1'b1, 8'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("post_rst2", 1'b1, 9'd0, 1'b1, 8'd2, 1'b0);

        // Stop word at PC 8: halts fetch when detection is built in, passes through otherwise.
        mem[4][63:32] = 32'd0;
        reset_dut();
        applyStimulus(1'b0, 1'b1, 9'd8);
        checkOutput("h0", 1'b0, 9'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h1", 1'b0, 9'd0, 1'b1, 8'd4, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h2", 1'b0, 9'd0, 1'b1, 8'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h3", 1'b1, 9'd8, !HALT_EN, 8'd6, HALT_EN);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h4", 1'b1, 9'd10, !HALT_EN, HALT_EN ? 8'd6 : 8'd7, HALT_EN);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h5", !HALT_EN, HALT_EN ? 9'd0 : 9'd12, !HALT_EN, HALT_EN ? 8'd6 : 8'd8, HALT_EN);
        applyStimulus(1'b0, 1'b1, 9'd20);
        checkOutput("h6", !HALT_EN, HALT_EN ? 9'd0 : 9'd14, 1'b0, HALT_EN ? 8'd6 : 8'd9, HALT_EN);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h7", 1'b0, 9'd0, 1'b1, 8'd10, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h8", 1'b0, 9'd0, 1'b1, 8'd11, 1'b0);
        applyStimulus(1'b0, 1'b0, 9'd0);
        checkOutput("h9", 1'b1, 9'd20, 1'b1, 8'd12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
